// File: rtl/seq_alu_if.sv
// seq_alu_if: request/response bundle between the execute-stage control and seq_alu.
// The master issues start/opcode/operands; the slave returns results and handshake status.
interface seq_alu_if #(
    parameter int WIDTH = 32
);
    localparam int SHW = $clog2(WIDTH);

    logic             start;
    logic [3:0]       ALUOperation;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] ALUResult;
    logic [WIDTH-1:0] HI;
    logic             Zero;
    logic             Overflow;
    logic             busy;
    logic             done;

    modport master (
        output start, ALUOperation, A, B, shamt,
        input  ALUResult, HI, Zero, Overflow, busy, done
    );

    modport slave (
        input  start, ALUOperation, A, B, shamt,
        output ALUResult, HI, Zero, Overflow, busy, done
    );
endinterface

// File: rtl/seq_alu.sv
// seq_alu: registered ALU with single-cycle logic/arith/shift ops and iterative
// MULTU/DIVU that is compiled in only when SEQ_ALU_MULDIV_EN is defined.
module seq_alu #(
    parameter int WIDTH = 32
) (
    input logic      clk,
    input logic      reset,
    seq_alu_if.slave bus
);
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_NOR = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0100;
    localparam logic [3:0] OP_SLL = 4'b0101;
    localparam logic [3:0] OP_SRL = 4'b0110;
    localparam logic [3:0] OP_SRA = 4'b0111;
    localparam logic [3:0] OP_SLT = 4'b1000;

    logic [WIDTH-1:0] sc_res_s;
    logic             sc_ov_s;
    logic             accept_s;
    logic             upd_s;
    logic [WIDTH-1:0] nres_s;
    logic [WIDTH-1:0] nhi_s;
    logic             nov_s;
    logic [WIDTH-1:0] res_r;
    logic [WIDTH-1:0] hi_r;
    logic             zero_r;
    logic             ov_r;
    logic             done_r;

    // Single-cycle datapath evaluated on the live request operands.
    always_comb begin
        sc_res_s = {WIDTH{1'b0}};
        sc_ov_s  = 1'b0;
        case (bus.ALUOperation)
            OP_AND: sc_res_s = bus.A & bus.B;
            OP_OR:  sc_res_s = bus.A | bus.B;
            OP_NOR: sc_res_s = ~(bus.A | bus.B);
            OP_ADD: begin
                sc_res_s = bus.A + bus.B;
                sc_ov_s  = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (sc_res_s[WIDTH-1] != bus.A[WIDTH-1]);
            end
            OP_SUB: begin
                sc_res_s = bus.A - bus.B;
                sc_ov_s  = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (sc_res_s[WIDTH-1] != bus.A[WIDTH-1]);
            end
            OP_SLL: sc_res_s = bus.A << bus.shamt;
            OP_SRL: sc_res_s = bus.A >> bus.shamt;
            OP_SRA: sc_res_s = $unsigned($signed(bus.A) >>> bus.shamt);
            OP_SLT: sc_res_s = {{(WIDTH-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
            default: begin
                sc_res_s = {WIDTH{1'b0}};
                sc_ov_s  = 1'b0;
            end
        endcase
    end

`ifdef SEQ_ALU_MULDIV_EN
    localparam int         SHW      = $clog2(WIDTH);
    localparam logic [3:0] OP_MULTU = 4'b1001;
    localparam logic [3:0] OP_DIVU  = 4'b1010;
    localparam logic [SHW:0] CNT_ONE  = {{SHW{1'b0}}, 1'b1};
    localparam logic [SHW:0] CNT_LOAD = (SHW+1)'(WIDTH);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t             state_r;
    state_t             state_s;
    logic [SHW:0]       cnt_r;
    logic [2*WIDTH-1:0] acc_r;
    logic [2*WIDTH-1:0] acc_s;
    logic [WIDTH-1:0]   opb_r;
    logic               is_div_r;
    logic               busy_r;
    logic               is_mul_s;
    logic               is_div_s;
    logic               div_zero_s;
    logic               last_s;
    logic [WIDTH:0]     mul_sum_s;
    logic [WIDTH:0]     div_trial_s;
    logic [WIDTH:0]     div_diff_s;

    assign accept_s   = bus.start && (state_r == IDLE);
    assign is_mul_s   = (bus.ALUOperation == OP_MULTU);
    assign is_div_s   = (bus.ALUOperation == OP_DIVU);
    assign div_zero_s = (bus.B == {WIDTH{1'b0}});
    assign last_s     = (state_r == RUN) && (cnt_r == CNT_ONE);

    // FSM state register; busy mirrors the registered state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s == RUN);
        end
    end

    // Next-state logic: divide-by-zero never enters RUN.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s && (is_mul_s || (is_div_s && !div_zero_s))) state_s = RUN;
                else                                                       state_s = IDLE;
            end
            RUN: begin
                if (last_s) state_s = IDLE;
                else        state_s = RUN;
            end
            default: state_s = IDLE;
        endcase
    end

    // One iteration: shift-add multiply (acc = {partial, multiplier}) or
    // restoring divide (acc = {remainder, dividend/quotient}).
    always_comb begin
        mul_sum_s   = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, (acc_r[0] ? opb_r : {WIDTH{1'b0}})};
        div_trial_s = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
        div_diff_s  = div_trial_s - {1'b0, opb_r};
        if (is_div_r) begin
            if (div_diff_s[WIDTH]) acc_s = {div_trial_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
            else                   acc_s = {div_diff_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
        end else begin
            acc_s = {mul_sum_s, acc_r[WIDTH-1:1]};
        end
    end

    // Operand latch, iteration counter and accumulator.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r    <= {(SHW+1){1'b0}};
            acc_r    <= {(2*WIDTH){1'b0}};
            opb_r    <= {WIDTH{1'b0}};
            is_div_r <= 1'b0;
        end else if ((state_r == IDLE) && (state_s == RUN)) begin
            cnt_r    <= CNT_LOAD;
            acc_r    <= {{WIDTH{1'b0}}, bus.A};
            opb_r    <= bus.B;
            is_div_r <= is_div_s;
        end else if (state_r == RUN) begin
            cnt_r <= cnt_r - CNT_ONE;
            acc_r <= acc_s;
        end
    end

    // Output selection: final iteration, divide-by-zero, or single-cycle op.
    always_comb begin
        upd_s  = 1'b0;
        nres_s = res_r;
        nhi_s  = hi_r;
        nov_s  = ov_r;
        if (last_s) begin
            upd_s  = 1'b1;
            nres_s = acc_s[WIDTH-1:0];
            nhi_s  = acc_s[2*WIDTH-1:WIDTH];
            nov_s  = 1'b0;
        end else if (accept_s && is_div_s && div_zero_s) begin
            upd_s  = 1'b1;
            nres_s = {WIDTH{1'b1}};
            nhi_s  = bus.A;
            nov_s  = 1'b0;
        end else if (accept_s && !is_mul_s && !is_div_s) begin
            upd_s  = 1'b1;
            nres_s = sc_res_s;
            nhi_s  = {WIDTH{1'b0}};
            nov_s  = sc_ov_s;
        end else begin
            upd_s = 1'b0;
        end
    end

    assign bus.busy = busy_r;
`else
    assign accept_s = bus.start;

    // Output selection: every accepted opcode completes in one cycle.
    always_comb begin
        upd_s  = 1'b0;
        nres_s = res_r;
        nhi_s  = hi_r;
        nov_s  = ov_r;
        if (accept_s) begin
            upd_s  = 1'b1;
            nres_s = sc_res_s;
            nhi_s  = {WIDTH{1'b0}};
            nov_s  = sc_ov_s;
        end else begin
            upd_s = 1'b0;
        end
    end

    assign bus.busy = 1'b0;
`endif

    // Result registers; next values already hold the old result when idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            res_r  <= {WIDTH{1'b0}};
            hi_r   <= {WIDTH{1'b0}};
            zero_r <= 1'b1;
            ov_r   <= 1'b0;
            done_r <= 1'b0;
        end else begin
            res_r  <= nres_s;
            hi_r   <= nhi_s;
            zero_r <= (nres_s == {WIDTH{1'b0}});
            ov_r   <= nov_s;
            done_r <= upd_s;
        end
    end

    assign bus.ALUResult = res_r;
    assign bus.HI        = hi_r;
    assign bus.Zero      = zero_r;
    assign bus.Overflow  = ov_r;
    assign bus.done      = done_r;
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: vector table plus scoreboard for seq_alu (WIDTH=32 and WIDTH=8),
// with hand-written sequences for busy, back-to-back, and reset corner cases.
module tb_seq_alu;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    seq_alu_if #(.WIDTH(32)) bus ();
    seq_alu_if #(.WIDTH(8))  bus8 ();

    seq_alu #(.WIDTH(32)) dut  (.clk(clk), .reset(reset), .bus(bus));
    seq_alu #(.WIDTH(8))  dut8 (.clk(clk), .reset(reset), .bus(bus8));

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a, b;
        logic [4:0]  sh;
        logic [31:0] res, hi;
        logic        zero, ov;
        int          lat, nbusy;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] res, hi;
        logic        zero, ov;
        int          due, nbusy;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    exp_t e_m;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   busy_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    function automatic vec_t mk(input string n, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [4:0] sh, input logic [31:0] res, input logic [31:0] hi,
                                input logic z, input logic ov, input int lat, input int nb);
        vec_t v;
        v.name = n; v.op = op; v.a = a; v.b = b; v.sh = sh;
        v.res = res; v.hi = hi; v.zero = z; v.ov = ov; v.lat = lat; v.nbusy = nb;
        return v;
    endfunction

    // Monitor: every done pops the scoreboard and checks values, latency and busy span.
    always @(negedge clk) begin
        if (reset) begin
            busy_cnt = 0;
        end else if (bus.done) begin
            if (sb.size() == 0) begin
                chk("spurious_done", {63'd0, bus.done}, 64'd0);
            end else begin
                e_m = sb.pop_front();
                chk({e_m.name, "_res"},  bus.ALUResult, e_m.res);
                chk({e_m.name, "_hi"},   bus.HI, e_m.hi);
                chk({e_m.name, "_zero"}, bus.Zero, e_m.zero);
                chk({e_m.name, "_ovf"},  bus.Overflow, e_m.ov);
                chk({e_m.name, "_lat"},  cyc, e_m.due);
                chk({e_m.name, "_busycycles"}, busy_cnt, e_m.nbusy);
                chk({e_m.name, "_busy_at_done"}, bus.busy, 1'b0);
            end
            busy_cnt = 0;
        end else if (bus.busy) begin
            busy_cnt++;
        end
    end

    // Drive a request at the current negedge and advance one cycle (start stays high).
    task automatic send(input vec_t v);
        exp_t e;
        bus.start = 1'b1; bus.ALUOperation = v.op; bus.A = v.a; bus.B = v.b; bus.shamt = v.sh;
        e.name = v.name; e.res = v.res; e.hi = v.hi; e.zero = v.zero; e.ov = v.ov;
        e.due = cyc + v.lat; e.nbusy = v.nbusy;
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle();
        bus.start = 1'b0;
        bus.ALUOperation = 4'($urandom_range(0, 15));
        bus.A = $urandom; bus.B = $urandom;
        bus.shamt = 5'($urandom_range(0, 31));
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while (sb.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_res"},  bus.ALUResult, 32'd0);
        chk({tag, "_hi"},   bus.HI, 32'd0);
        chk({tag, "_zero"}, bus.Zero, 1'b1);
        chk({tag, "_ovf"},  bus.Overflow, 1'b0);
        chk({tag, "_busy"}, bus.busy, 1'b0);
        chk({tag, "_done"}, bus.done, 1'b0);
    endtask

    initial begin
        int k;
        vecs.push_back(mk("add_ovf",  4'h3, 32'h7FFFFFFF, 32'h1, 5'd0, 32'h80000000, 32'h0, 1'b0, 1'b1, 1, 0));
        vecs.push_back(mk("sub_zero", 4'h4, 32'd5, 32'd5, 5'd0, 32'h0, 32'h0, 1'b1, 1'b0, 1, 0));
        vecs.push_back(mk("sra",      4'h7, 32'h80000000, 32'h0, 5'd4, 32'hF8000000, 32'h0, 1'b0, 1'b0, 1, 0));
        vecs.push_back(mk("slt_neg",  4'h8, 32'hFFFFFFFF, 32'h1, 5'd0, 32'h1, 32'h0, 1'b0, 1'b0, 1, 0));
        vecs.push_back(mk("slt_pos",  4'h8, 32'h1, 32'hFFFFFFFF, 5'd0, 32'h0, 32'h0, 1'b1, 1'b0, 1, 0));
        vecs.push_back(mk("and",      4'h0, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd0, 32'h00F000F0, 32'h0, 1'b0, 1'b0, 1, 0));
        vecs.push_back(mk("or",       4'h1, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd0, 32'hFFF0FFF0, 32'h0, 1'b0, 1'b0, 1, 0));
        vecs.push_back(mk("nor",      4'h2, 32'h0, 32'h0, 5'd0, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0, 1, 0));
        vecs.push_back(mk("sll31",    4'h5, 32'h1, 32'h0, 5'd31, 32'h80000000, 32'h0, 1'b0, 1'b0, 1, 0));
        vecs.push_back(mk("srl31",    4'h6, 32'h80000000, 32'h0, 5'd31, 32'h1, 32'h0, 1'b0, 1'b0, 1, 0));
        vecs.push_back(mk("sub_ovf",  4'h4, 32'h80000000, 32'h1, 5'd0, 32'h7FFFFFFF, 32'h0, 1'b0, 1'b1, 1, 0));
        vecs.push_back(mk("add_wrap", 4'h3, 32'hFFFFFFFF, 32'h1, 5'd0, 32'h0, 32'h0, 1'b1, 1'b0, 1, 0));
        vecs.push_back(mk("add_negov",4'h3, 32'h80000000, 32'h80000000, 5'd0, 32'h0, 32'h0, 1'b1, 1'b1, 1, 0));
        vecs.push_back(mk("unknown",  4'hF, 32'h12345678, 32'h9ABCDEF0, 5'd3, 32'h0, 32'h0, 1'b1, 1'b0, 1, 0));
`ifdef SEQ_ALU_MULDIV_EN
        vecs.push_back(mk("multu",    4'h9, 32'hFFFFFFFF, 32'h2, 5'd0, 32'hFFFFFFFE, 32'h1, 1'b0, 1'b0, 33, 32));
        vecs.push_back(mk("multu_0",  4'h9, 32'h0, 32'h5, 5'd0, 32'h0, 32'h0, 1'b1, 1'b0, 33, 32));
        vecs.push_back(mk("divu",     4'hA, 32'd100, 32'd7, 5'd0, 32'd14, 32'd2, 1'b0, 1'b0, 33, 32));
        vecs.push_back(mk("divu_small",4'hA, 32'd5, 32'd9, 5'd0, 32'd0, 32'd5, 1'b1, 1'b0, 33, 32));
        vecs.push_back(mk("divu_by0", 4'hA, 32'd9, 32'd0, 5'd0, 32'hFFFFFFFF, 32'd9, 1'b0, 1'b0, 1, 0));
`else
        vecs.push_back(mk("multu_off",4'h9, 32'hFFFFFFFF, 32'h2, 5'd0, 32'h0, 32'h0, 1'b1, 1'b0, 1, 0));
        vecs.push_back(mk("divu_off", 4'hA, 32'd9, 32'd0, 5'd0, 32'h0, 32'h0, 1'b1, 1'b0, 1, 0));
`endif

        reset = 1'b1;
        idle();
        bus8.start = 1'b0; bus8.ALUOperation = 4'h0; bus8.A = 8'h0; bus8.B = 8'h0; bus8.shamt = 3'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk_reset_vals("reset");
        chk("w8_reset_zero", bus8.Zero, 1'b1);

        foreach (vecs[i]) begin
            send(vecs[i]);
            idle();
            drain(60);
        end

        // Back-to-back single-cycle requests, one accepted per cycle.
        send(mk("b2b_add", 4'h3, 32'd1, 32'd2, 5'd0, 32'd3, 32'd0, 1'b0, 1'b0, 1, 0));
        send(mk("b2b_sub", 4'h4, 32'd10, 32'd3, 5'd0, 32'd7, 32'd0, 1'b0, 1'b0, 1, 0));
        send(mk("b2b_slt", 4'h8, 32'hFFFFFFF0, 32'd4, 5'd0, 32'd1, 32'd0, 1'b0, 1'b0, 1, 0));
        idle();
        drain(10);

`ifdef SEQ_ALU_MULDIV_EN
        // Ignored starts while busy, then a new request accepted in the done cycle.
        send(mk("mul_busy", 4'h9, 32'd3, 32'd5, 5'd0, 32'd15, 32'd0, 1'b0, 1'b0, 33, 32));
        idle();
        for (int c = 2; c <= 33; c++) begin
            @(negedge clk);
            if (c == 5 || c == 20 || c == 32) begin
                bus.start = 1'b1; bus.ALUOperation = 4'h3; bus.A = 32'd1; bus.B = 32'd1;
            end else begin
                idle();
            end
        end
        send(mk("add_in_done", 4'h3, 32'd7, 32'd8, 5'd0, 32'd15, 32'd0, 1'b0, 1'b0, 1, 0));
        idle();
        drain(10);
`endif

        // Reset aborts work in flight and beats a simultaneous start.
        send(mk("add_pre_rst", 4'h3, 32'h12, 32'h34, 5'd0, 32'h46, 32'd0, 1'b0, 1'b0, 1, 0));
        idle();
        drain(10);
`ifdef SEQ_ALU_MULDIV_EN
        send(mk("mul_abort", 4'h9, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0, 32'd1, 32'hFFFFFFFE, 1'b0, 1'b0, 33, 32));
        idle();
        repeat (9) @(negedge clk);
        sb.delete();
`endif
        reset = 1'b1;
        bus.start = 1'b1; bus.ALUOperation = 4'h3; bus.A = 32'd40; bus.B = 32'd2;
        @(negedge clk);
        reset = 1'b0;
        idle();
        chk_reset_vals("rst_abort");
        repeat (40) @(negedge clk);
        send(mk("add_post_rst", 4'h3, 32'd2, 32'd3, 5'd0, 32'd5, 32'd0, 1'b0, 1'b0, 1, 0));
        idle();
        drain(10);

        // WIDTH=8 instance.
        bus8.start = 1'b1; bus8.ALUOperation = 4'h3; bus8.A = 8'h7F; bus8.B = 8'h01;
        @(negedge clk);
        bus8.start = 1'b0;
        chk("w8_add_done", bus8.done, 1'b1);
        chk("w8_add_res", bus8.ALUResult, 8'h80);
        chk("w8_add_ovf", bus8.Overflow, 1'b1);
        bus8.start = 1'b1; bus8.ALUOperation = 4'h9; bus8.A = 8'hFF; bus8.B = 8'hFF;
        @(negedge clk);
        bus8.start = 1'b0; bus8.A = 8'h00; bus8.B = 8'h00;
        k = 1;
        while (!bus8.done && k < 20) begin
            @(negedge clk);
            k++;
        end
`ifdef SEQ_ALU_MULDIV_EN
        chk("w8_mul_lat", 64'(k), 64'd9);
        chk("w8_mul_lo", bus8.ALUResult, 8'h01);
        chk("w8_mul_hi", bus8.HI, 8'hFE);
`else
        chk("w8_mul_lat", 64'(k), 64'd1);
        chk("w8_mul_lo", bus8.ALUResult, 8'h00);
        chk("w8_mul_hi", bus8.HI, 8'h00);
`endif
        chk("w8_mul_done", bus8.done, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, registered successor to the single-cycle datapath ALU. It runs the existing logic, arithmetic and shift operations in one cycle. It adds SRA, SLT and multi-cycle unsigned multiply/divide behind a start/busy/done handshake. It sits in the execute stage, and the control FSM stalls on `busy`.

## Interface
- `WIDTH`, 32, operand/result width (≥ 4, power of two); local `SHW` = $clog2(WIDTH) is the shift-amount width.
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: request; accepted only when `busy`=0.
- `ALUOperation` in 4: opcode, sampled on accept.
- `A`, `B` in WIDTH: operands, sampled on accept.
- `shamt` in SHW: shift amount, sampled on accept.
- `ALUResult` out WIDTH: result, or LO product / quotient.
- `HI` out WIDTH: upper product / remainder; 0 for other ops.
- `Zero` out 1: `ALUResult`==0.
- `Overflow` out 1: signed overflow, ADD/SUB only; else 0.
- `busy` out 1: multi-cycle op in progress.
- `done` out 1: one-cycle pulse when outputs are updated.

## Operation
- Opcodes:
  - AND 0000, OR 0001, NOR 0010, ADD 0011, SUB 0100.
  - SLL 0101, SRL 0110 (A shifted by `shamt`).
  - SRA 0111 (A arithmetic right by `shamt`).
  - SLT 1000 (signed A<B → 1, else 0).
  - MULTU 1001, DIVU 1010.
  - Others: result 0, single-cycle.
- FSM states: IDLE, RUN.
- **IDLE**
  - On `start`, a single-cycle op registers `ALUResult`/`HI`/`Zero`/`Overflow` and pulses `done`.
  - On `start`, MULTU/DIVU latches operands, loads counter=WIDTH and goes to RUN.
- **RUN**
  - Performs one iteration per cycle.
  - MULTU is shift-add over a 2·WIDTH accumulator.
  - DIVU is restoring division, one quotient bit per cycle.
  - Counter decrements each cycle. On the final iteration, outputs are written, `done` pulses and the FSM returns to IDLE.
- Arithmetic rules:
  - ADD/SUB wrap modulo 2^WIDTH.
  - `Overflow` = operand signs agree (ADD) or differ (SUB) and the result sign differs from A.
- DIVU with B=0: completes in one cycle without entering RUN; `ALUResult` = all ones, `HI` = A.
- `start` while `busy`=1 is ignored: no effect, and no queued request.
- Input changes after accept do not affect an operation in flight.
- Outputs hold their last value until the next `done`.

## Timing
- Reset values:
  - `ALUResult`, `HI`, `Overflow`, `busy`, `done` = 0.
  - `Zero` = 1.
  - FSM = IDLE, counter = 0.
- Single-cycle ops and DIVU-by-0 have latency 1: `done`=1 and outputs are valid in the cycle after the accepting edge.
- MULTU/DIVU:
  - `busy`=1 for cycles 1..WIDTH after the accepting edge.
  - `done`=1 and outputs valid in cycle WIDTH+1, with `busy`=0.
- A new `start` is accepted in the `done` cycle, giving back-to-back throughput.
- `reset` mid-RUN aborts: outputs return to reset values next cycle, and no `done` pulses.
- `reset` and `start` in the same cycle: reset wins.

## Configuration
- Macro `SEQ_ALU_MULDIV_EN`.
- Defined: MULTU/DIVU, the RUN state, the counter and the accumulator are compiled in.
- Undefined:
  - No RUN logic; `busy` is tied to 0.
  - Opcodes 1001/1010 behave as unknown opcodes: result 0, `HI` 0, `done` in 1 cycle.

## Test plan
- ADD, A=0x7FFFFFFF, B=1 → `ALUResult`=0x80000000, `Overflow`=1, `Zero`=0, `done` one cycle after start.
- SUB 5−5 → `Zero`=1. SRA A=0x80000000, shamt=4 → 0xF8000000. SLT A=−1, B=1 → 1.
- MULTU 0xFFFFFFFF×2 → `HI`=1, `ALUResult`=0xFFFFFFFE; `busy` for 32 cycles; `done` in cycle 33. Extra `start` pulses during `busy` are ignored.
- DIVU 100/7 → `ALUResult`=14, `HI`=2 after 33 cycles. DIVU 9/0 → 0xFFFFFFFF, `HI`=9 in 1 cycle.
- `reset` asserted in cycle 10 of a MULTU → all outputs at reset values next cycle, no `done`. A following ADD completes normally.
- WIDTH=8 instance: MULTU 0xFF×0xFF → `HI`=0xFE, `ALUResult`=0x01, `done` in cycle 9. Build without `SEQ_ALU_MULDIV_EN` → MULTU returns 0 in 1 cycle.
